// File: rtl/uart_tx_core_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_core_pkg
// Shared UART definitions used by the transmit core and, later, the receive
// core. Holds the FSM state encoding, clock/baud constants, and the parity
// helper so both directions agree on the frame format.
//
// Contents:
//   uart_state_e      3-bit frame state encoding (IDLE/START/DATA/PARITY/STOP)
//   CLK_FREQ_HZ       system clock frequency
//   DEFAULT_BAUD_DIV  clocks per bit at the default baud rate
//   MAX_DATA_BITS     widest data field a frame may carry
//   BIT_IDX_W         width of the per-frame bit index
//   frame_parity()    even parity of a data word, optionally inverted to odd
// -----------------------------------------------------------------------------
package uart_tx_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int CLK_FREQ_HZ       = 100_000_000;
    localparam int DEFAULT_BAUD_RATE = 115_200;
    // Integer division gives 868 clocks per bit (0.006 % rate error).
    localparam int DEFAULT_BAUD_DIV  = CLK_FREQ_HZ / DEFAULT_BAUD_RATE;

    localparam int MAX_DATA_BITS = 8;
    // Indexes data bits (0..7) and stop bits (0..1).
    localparam int BIT_IDX_W     = 3;

    // Unused upper bits of the data word must be zero so they do not
    // disturb the XOR reduction.
    function automatic logic frame_parity(input logic [MAX_DATA_BITS-1:0] data,
                                          input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Bit-period timer shared by the UART transmit and receive cores. Counts
// 0..DIV-1 while clear is low and strobes bit_end on the last count of each
// bit period. Holding clear high parks the counter at 0, so the first period
// after clear drops is always a full DIV clocks.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst_n    in   asynchronous reset, active low
//   clear    in   synchronous clear; counter held at 0 while high
//   bit_end  out  one-cycle strobe on the final clock of a bit period
// -----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int DIV = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, as real hardware does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear || (count_q == LAST_COUNT)) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bit_end = !clear && (count_q == LAST_COUNT);

endmodule

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// UART transmitter. Accepts one data word per valid/ready handshake and sends
// it as an asynchronous frame: start bit (0), DATA_BITS data bits LSB first,
// an optional parity bit, and STOP_BITS stop bits (1). Every bit lasts
// exactly BAUD_DIV clocks; the bit timer restarts on each accept.
//
// Parameters:
//   BAUD_DIV    clocks per bit (>= 2)
//   DATA_BITS   data bits per frame (5..8)
//   PARITY_EN   1 inserts a parity bit after the data
//   PARITY_ODD  1 selects odd parity, 0 even
//   STOP_BITS   1 or 2 stop bits
//
// Ports:
//   clk       in   system clock, rising-edge active
//   rst_n     in   asynchronous reset, active low
//   tx_data   in   word to send; sampled only on accept
//   tx_valid  in   upstream has a word
//   tx_ready  out  core can accept (IDLE)
//   tx_busy   out  frame in progress
//   tx_done   out  one-cycle pulse in the first IDLE cycle after a frame
//   uart_txd  out  serial line, idle high, driven from a flop
// -----------------------------------------------------------------------------
module uart_tx_core
    import uart_tx_core_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 uart_txd
);

    // ------------------------------------------------------------------
    // Parameter legality: stop elaboration on unsupported configurations.
    // ------------------------------------------------------------------
    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_tx_core: BAUD_DIV must be >= 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > MAX_DATA_BITS)) begin : g_bad_data_bits
        $error("uart_tx_core: DATA_BITS must be in 5..8");
    end
    if ((PARITY_EN != 0) && (PARITY_EN != 1)) begin : g_bad_parity_en
        $error("uart_tx_core: PARITY_EN must be 0 or 1");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
        $error("uart_tx_core: PARITY_ODD must be 0 or 1");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx_core: STOP_BITS must be 1 or 2");
    end

    localparam logic [BIT_IDX_W-1:0] LAST_DATA_IDX = BIT_IDX_W'(DATA_BITS - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_STOP_IDX = BIT_IDX_W'(STOP_BITS - 1);
    localparam logic                 ODD_SEL       = (PARITY_ODD != 0);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    uart_state_e            state_q,   state_d;
    logic [DATA_BITS-1:0]   shreg_q,   shreg_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic                   parity_q,  parity_d;
    logic                   txd_q,     txd_d;
    logic                   done_q,    done_d;

    logic                   baud_clear;
    logic                   bit_end;
    logic [MAX_DATA_BITS-1:0] data_ext;

    // Zero-extend the input word so parity works for any DATA_BITS.
    always_comb begin
        data_ext                = '0;
        data_ext[DATA_BITS-1:0] = tx_data;
    end

    // The timer is held in clear for the whole IDLE state, which covers the
    // accept cycle: the start bit therefore always begins at count 0.
    baud_tick_gen #(
        .DIV (BAUD_DIV)
    ) u_baud_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (baud_clear),
        .bit_end (bit_end)
    );

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        parity_d   = parity_q;
        txd_d      = txd_q;
        done_d     = 1'b0;
        baud_clear = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                baud_clear = 1'b1;
                txd_d      = 1'b1;
                if (tx_valid) begin
                    state_d   = ST_START;
                    shreg_d   = tx_data;
                    parity_d  = frame_parity(data_ext, ODD_SEL);
                    bit_idx_d = '0;
                    txd_d     = 1'b0;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    txd_d     = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_DATA_IDX) begin
                        bit_idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            txd_d   = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                    txd_d     = 1'b1;
                end
            end

            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    if (bit_idx_q == LAST_STOP_IDX) begin
                        state_d   = ST_IDLE;
                        bit_idx_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bit_idx_d = '0;
                txd_d     = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: the shift register and parity flop are reset along with the
    // control state; they are few bits and a known value keeps the line
    // and simulation deterministic after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_ready = (state_q == ST_IDLE);
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_done  = done_q;
    assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_core
// Self-checking bench for uart_tx_core. Four instances cover the
// configurations of interest:
//   0: BAUD_DIV=4, no parity, 1 stop
//   1: BAUD_DIV=4, even parity, 1 stop
//   2: BAUD_DIV=4, odd parity, 1 stop
//   3: BAUD_DIV=868, no parity, 2 stops
// Expected line levels come from a frame model built from the bit-level
// frame format (start, data LSB first, parity, stops), expanded to BAUD_DIV
// clocks per bit.
// -----------------------------------------------------------------------------
module tb_uart_tx_core;

    localparam int N_DUT = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] tx_data  [N_DUT];
    logic       tx_valid [N_DUT];
    logic       tx_ready [N_DUT];
    logic       tx_busy  [N_DUT];
    logic       tx_done  [N_DUT];
    logic       uart_txd [N_DUT];

    int vectors     = 0;
    int miscompares = 0;

    int exp_bits[$];   // expected line level per bit of the current frame
    int trace[$];      // line level per clock of the last checked frame

    // Configuration of the three BAUD_DIV=4 instances, for random frames.
    int pe_of  [3] = '{0, 1, 1};
    int odd_of [3] = '{0, 0, 1};

    // ------------------------------------------------------------------
    // DUTs
    // ------------------------------------------------------------------
    uart_tx_core #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .uart_txd(uart_txd[0]));

    uart_tx_core #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .uart_txd(uart_txd[1]));

    uart_tx_core #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]), .uart_txd(uart_txd[2]));

    uart_tx_core #(.BAUD_DIV(868), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]), .uart_txd(uart_txd[3]));

    always #5 clk = ~clk;

    // Line-idle run length and tx_done pulse count for instance 0.
    int high_run      = 0;
    int last_high_run = 0;
    int done_cnt0     = 0;

    always @(negedge clk) begin
        if (uart_txd[0] === 1'b1) begin
            high_run = high_run + 1;
        end else begin
            if (high_run != 0) last_high_run = high_run;
            high_run = 0;
        end
        if (tx_done[0] === 1'b1) done_cnt0 = done_cnt0 + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached (observed running, required finished)");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Checking and model
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors = vectors + 1;
        assert (observed === expected) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Frame as a list of bit levels: start, data LSB first, parity, stops.
    task automatic model_frame(input logic [7:0] data, input int pe, input int odd, input int stops);
        int ones = 0;
        exp_bits.delete();
        exp_bits.push_back(0);
        for (int i = 0; i < 8; i++) begin
            int b = (int'(data) / (1 << i)) % 2;
            exp_bits.push_back(b);
            ones += b;
        end
        if (pe != 0) exp_bits.push_back((odd != 0) ? 1 - (ones % 2) : (ones % 2));
        for (int s = 0; s < stops; s++) exp_bits.push_back(1);
    endtask

    // Waits (bounded) for ready, presents data, returns #1 after the accept edge.
    task automatic start_frame(input int i, input logic [7:0] data, input bit hold);
        int waited = 0;
        @(negedge clk);
        while (tx_ready[i] !== 1'b1 && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", 32'(tx_ready[i]), 32'd1);
        tx_data[i]  = data;
        tx_valid[i] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tx_valid[i] = 1'b0;
    endtask

    // Checks every clock of the frame against exp_bits, then the done cycle.
    // Returns at the negedge of the first IDLE cycle.
    task automatic check_frame(input int i, input int div, input string tag);
        trace.delete();
        for (int b = 0; b < exp_bits.size(); b++) begin
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                trace.push_back(int'(uart_txd[i]));
                check({tag, "_txd"}, 32'(uart_txd[i]), 32'(exp_bits[b]));
                if (c == 0) begin
                    check({tag, "_ready_low"}, 32'(tx_ready[i]), 32'd0);
                    check({tag, "_busy_high"}, 32'(tx_busy[i]), 32'd1);
                    check({tag, "_done_low"},  32'(tx_done[i]),  32'd0);
                end
            end
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(tx_done[i]),  32'd1);
        check({tag, "_done_ready"}, 32'(tx_ready[i]), 32'd1);
        check({tag, "_done_busy"},  32'(tx_busy[i]),  32'd0);
        check({tag, "_done_txd"},   32'(uart_txd[i]), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Directed and random steps
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] rx_byte;
        int         saved_done;

        for (int i = 0; i < N_DUT; i++) begin
            tx_data[i]  = 8'h00;
            tx_valid[i] = 1'b0;
        end

        // Reset state (while rst_n is still low).
        #500;
        for (int i = 0; i < N_DUT; i++) begin
            check("reset_txd",   32'(uart_txd[i]), 32'd1);
            check("reset_ready", 32'(tx_ready[i]), 32'd1);
            check("reset_busy",  32'(tx_busy[i]),  32'd0);
            check("reset_done",  32'(tx_done[i]),  32'd0);
        end
        #500;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Step 1: 0xA5, no parity; done in clock 41 after accept.
        model_frame(8'hA5, 0, 0, 1);
        start_frame(0, 8'hA5, 1'b0);
        check_frame(0, 4, "t1");
        @(negedge clk);
        check("t1_done_one_cycle", 32'(tx_done[0]), 32'd0);

        // Step 2: parity variants.
        model_frame(8'hA5, 1, 0, 1);
        start_frame(1, 8'hA5, 1'b0);
        check_frame(1, 4, "t2_even_a5");
        model_frame(8'hA5, 1, 1, 1);
        start_frame(2, 8'hA5, 1'b0);
        check_frame(2, 4, "t2_odd_a5");
        model_frame(8'h07, 1, 0, 1);
        start_frame(1, 8'h07, 1'b0);
        check_frame(1, 4, "t2_even_07");

        // Step 3: back-to-back with tx_valid held; 0x00 then 0xFF.
        model_frame(8'h00, 0, 0, 1);
        start_frame(0, 8'h00, 1'b1);
        tx_data[0] = 8'hFF;
        check_frame(0, 4, "t3a");
        model_frame(8'hFF, 0, 0, 1);
        @(posedge clk);
        #1;
        tx_valid[0] = 1'b0;
        check_frame(0, 4, "t3b");
        check("t3_gap_high_clocks", 32'(last_high_run), 32'd5);

        // Step 4: mid-frame data change and valid pulse are ignored.
        model_frame(8'h96, 0, 0, 1);
        start_frame(0, 8'h96, 1'b0);
        fork
            check_frame(0, 4, "t4");
            begin
                repeat (10) @(negedge clk);
                tx_data[0]  = 8'h3C;
                tx_valid[0] = 1'b1;
                @(negedge clk);
                tx_valid[0] = 1'b0;
            end
        join
        repeat (8) @(negedge clk);
        check("t4_no_extra_txd",  32'(uart_txd[0]), 32'd1);
        check("t4_no_extra_busy", 32'(tx_busy[0]),  32'd0);

        // Step 5: reset during data bit 3 (clocks 17..20 after accept).
        saved_done = done_cnt0;
        start_frame(0, 8'hC3, 1'b0);
        repeat (18) @(negedge clk);
        check("t5_bit3_low", 32'(uart_txd[0]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_txd",   32'(uart_txd[0]), 32'd1);
        check("t5_async_ready", 32'(tx_ready[0]), 32'd1);
        check("t5_async_busy",  32'(tx_busy[0]),  32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        check("t5_no_done", 32'(done_cnt0), 32'(saved_done));
        check("t5_idle_txd", 32'(uart_txd[0]), 32'd1);
        model_frame(8'h5A, 0, 0, 1);
        start_frame(0, 8'h5A, 1'b0);
        check_frame(0, 4, "t5_after");

        // Random frames across the BAUD_DIV=4 configurations.
        for (int n = 0; n < 12; n++) begin
            int         k    = int'($urandom_range(0, 2));
            logic [7:0] data = 8'($urandom_range(0, 255));
            int         gap  = int'($urandom_range(0, 3));
            model_frame(data, pe_of[k], odd_of[k], 1);
            start_frame(k, data, 1'b0);
            check_frame(k, 4, "rand");
            repeat (gap) @(negedge clk);
        end

        // Step 6: 868 clocks per bit, 2 stops, decoded by mid-bit sampling.
        model_frame(8'h55, 0, 0, 2);
        start_frame(3, 8'h55, 1'b0);
        check_frame(3, 868, "t6");
        check("t6_frame_clocks", 32'(trace.size()), 32'(868 * 11));
        rx_byte = 8'h00;
        for (int b = 0; b < 8; b++) begin
            rx_byte[b] = trace[(1 + b) * 868 + 434][0];
        end
        check("t6_rx_start", 32'(trace[434]), 32'd0);
        check("t6_rx_byte",  32'(rx_byte), 32'h55);
        check("t6_rx_stop1", 32'(trace[9 * 868 + 434]), 32'd1);
        check("t6_rx_stop2", 32'(trace[10 * 868 + 434]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
